// File: rtl/itag_bist_ctl.sv
// ---------------------------------------------------------------------------
// itag_bist_ctl
//
// Built-in self test controller for the I-cache tag array. While a run is
// active it owns the tag array write/read port (through the wrapper mux),
// runs a 6-element march over every tag entry and compares the read-back
// {itag_vld, itag_dout} against the expected background. A clear-only run
// just writes {vld=0, tag=0} to every entry.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   test_mode           BIST enable; dropping it aborts back to IDLE
//   bist_mode[1:0]      00 none, 01 march/solid, 10 march/checkerboard,
//                       11 clear-only (sampled only when a run starts)
//   itag_dout, itag_vld tag array read data, valid one cycle after address
//   bist_active         wrapper selects the BIST inputs
//   bist_enable         array enable during test
//   bist_icu_tag_addr   array index
//   bist_icu_tag_we     array write enable
//   bist_icu_tag_in     write tag data
//   bist_icu_tag_vld    write valid bit
//   bist_done           run completed
//   itag_test_err_l     0 = at least one miscompare (sticky)
//   bist_fail_addr      index of the first miscompare
// ---------------------------------------------------------------------------
module itag_bist_ctl #(
  parameter int TAG_W  = 18,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test_mode,
  input  logic [1:0]        bist_mode,
  input  logic [TAG_W-1:0]  itag_dout,
  input  logic              itag_vld,
  output logic              bist_active,
  output logic              bist_enable,
  output logic [ADDR_W-1:0] bist_icu_tag_addr,
  output logic              bist_icu_tag_we,
  output logic [TAG_W-1:0]  bist_icu_tag_in,
  output logic              bist_icu_tag_vld,
  output logic              bist_done,
  output logic              itag_test_err_l,
  output logic [ADDR_W-1:0] bist_fail_addr
);

  localparam int                DW        = TAG_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              cb_q;
  logic              clr_q;
  logic              err_l_q;
  logic [ADDR_W-1:0] fail_q;

  logic              start;
  logic              is_march;
  logic              descending;
  logic              last_addr;
  logic              compare_en;
  logic              miscompare;
  logic [DW-1:0]     pat;
  logic [DW-1:0]     exp_data;
  logic [DW-1:0]     wr_data;

  // Background for one entry: all zero for the solid pattern, or the
  // alternating 1010..10 pattern inverted on odd indices for checkerboard,
  // so neighbouring entries and neighbouring bits always differ.
  function automatic logic [DW-1:0] background(input logic cb, input logic a0);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < DW; i++) begin
      p[i] = cb & (a0 ^ ((i % 2) == 1));
    end
    return p;
  endfunction

  assign start      = test_mode && (bist_mode != 2'b00);
  assign is_march   = state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
  assign descending = state_q inside {S_M3, S_M4, S_M5};
  assign last_addr  = descending ? (addr_q == '0) : (addr_q == ADDR_LAST);
  assign pat        = background(cb_q, addr_q[0]);

  // Element sequencing. M0 touches one address per cycle; M1..M5 spend a
  // read cycle then a write/compare cycle on each address. The last address
  // of an element hands straight over to the first address of the next one.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_M0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!test_mode) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!test_mode) begin
          state_d = S_IDLE;
          phase_d = 1'b0;
        end else if ((state_q != S_M0) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_addr) begin
            case (state_q)
              S_M0: begin
                state_d = clr_q ? S_DONE : S_M1;
                addr_d  = '0;
              end
              S_M1: begin
                state_d = S_M2;
                addr_d  = '0;
              end
              S_M2: begin
                state_d = S_M3;
                addr_d  = ADDR_LAST;
              end
              S_M3: begin
                state_d = S_M4;
                addr_d  = ADDR_LAST;
              end
              S_M4: begin
                state_d = S_M5;
                addr_d  = ADDR_LAST;
              end
              default: begin
                state_d = S_DONE;
                addr_d  = '0;
              end
            endcase
          end else begin
            addr_d = descending ? (addr_q - 1'b1) : (addr_q + 1'b1);
          end
        end
      end
    endcase
  end

  // Expected read data and new write data for the current element.
  always_comb begin
    exp_data = pat;
    wr_data  = '0;
    case (state_q)
      S_M0: wr_data = clr_q ? '0 : pat;
      S_M1: begin
        exp_data = pat;
        wr_data  = ~pat;
      end
      S_M2: begin
        exp_data = ~pat;
        wr_data  = pat;
      end
      S_M3: begin
        exp_data = pat;
        wr_data  = ~pat;
      end
      S_M4: begin
        exp_data = ~pat;
        wr_data  = pat;
      end
      default: ;
    endcase
  end

  // Read data lands in the second cycle of each address, which is also where
  // the write-back happens, so the compare and the write share that cycle.
  assign compare_en = phase_q && (state_q inside {S_M1, S_M2, S_M3, S_M4, S_M5});
  assign miscompare = compare_en && ({itag_vld, itag_dout} != exp_data);

  assign bist_active       = is_march;
  assign bist_enable       = is_march;
  assign bist_icu_tag_addr = is_march ? addr_q : '0;
  assign bist_icu_tag_we   = (state_q == S_M0) ||
                             (phase_q && (state_q inside {S_M1, S_M2, S_M3, S_M4}));
  assign bist_icu_tag_in   = bist_icu_tag_we ? wr_data[TAG_W-1:0] : '0;
  assign bist_icu_tag_vld  = bist_icu_tag_we & wr_data[TAG_W];
  assign bist_done         = (state_q == S_DONE);
  assign itag_test_err_l   = err_l_q;
  assign bist_fail_addr    = fail_q;

  // State register plus run configuration and sticky result. The error flag
  // and failing index survive an abort so they can still be read out; only
  // reset or a new run clears them. Only the first failing index is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      cb_q    <= 1'b0;
      clr_q   <= 1'b0;
      err_l_q <= 1'b1;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      if ((state_q == S_IDLE) && start) begin
        cb_q    <= (bist_mode == 2'b10);
        clr_q   <= (bist_mode == 2'b11);
        err_l_q <= 1'b1;
        fail_q  <= '0;
      end else if (miscompare) begin
        err_l_q <= 1'b0;
        if (err_l_q) begin
          fail_q <= addr_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_itag_bist_ctl.sv
// ---------------------------------------------------------------------------
// tb_itag_bist_ctl
//
// Bench for itag_bist_ctl with a 16-entry tag array. A small synchronous-read
// RAM stands in for the tag array, with an optional stuck-at-1 on tag bit 3
// of entry 5. Directed vectors with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_itag_bist_ctl;

  localparam int TAG_W  = 18;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              test_mode;
  logic [1:0]        bist_mode;
  logic [TAG_W-1:0]  itag_dout;
  logic              itag_vld;
  logic              bist_active;
  logic              bist_enable;
  logic [ADDR_W-1:0] bist_icu_tag_addr;
  logic              bist_icu_tag_we;
  logic [TAG_W-1:0]  bist_icu_tag_in;
  logic              bist_icu_tag_vld;
  logic              bist_done;
  logic              itag_test_err_l;
  logic [ADDR_W-1:0] bist_fail_addr;

  logic [TAG_W:0]    mem [16];
  logic [TAG_W:0]    rd_q;
  logic              fault_en;

  int                n_checks;
  int                n_fail;
  int                cyc;

  typedef struct packed {
    logic [1:0]  mode;
    int          cyc;
    logic        active;
    logic        we;
    logic [3:0]  addr;
    logic [18:0] wdata;
    logic        done;
    logic        err_l;
  } vec_t;

  vec_t vecs[$];

  itag_bist_ctl #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .test_mode         (test_mode),
    .bist_mode         (bist_mode),
    .itag_dout         (itag_dout),
    .itag_vld          (itag_vld),
    .bist_active       (bist_active),
    .bist_enable       (bist_enable),
    .bist_icu_tag_addr (bist_icu_tag_addr),
    .bist_icu_tag_we   (bist_icu_tag_we),
    .bist_icu_tag_in   (bist_icu_tag_in),
    .bist_icu_tag_vld  (bist_icu_tag_vld),
    .bist_done         (bist_done),
    .itag_test_err_l   (itag_test_err_l),
    .bist_fail_addr    (bist_fail_addr)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array stand-in: write-enable honoured on the edge, read data one
  // cycle after the address, optional stuck-at-1 on tag bit 3 of entry 5.
  always @(posedge clk) begin
    if (bist_icu_tag_we) begin
      mem[bist_icu_tag_addr] <= {bist_icu_tag_vld, bist_icu_tag_in};
    end
    if (fault_en && (bist_icu_tag_addr == 4'd5)) begin
      rd_q <= mem[bist_icu_tag_addr] | 19'h00008;
    end else begin
      rd_q <= mem[bist_icu_tag_addr];
    end
  end

  assign itag_dout = rd_q[TAG_W-1:0];
  assign itag_vld  = rd_q[TAG_W];

  function automatic vec_t mk(input logic [1:0] mode, input int c, input logic active,
                              input logic we, input logic [3:0] addr,
                              input logic [18:0] wdata, input logic done,
                              input logic err_l);
    vec_t v;
    v.mode   = mode;
    v.cyc    = c;
    v.active = active;
    v.we     = we;
    v.addr   = addr;
    v.wdata  = wdata;
    v.done   = done;
    v.err_l  = err_l;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Start a run from IDLE; the start edge becomes cycle 0. bist_mode is
  // cleared right after to confirm it is only sampled at start.
  task automatic applyStimulus(input logic [1:0] mode);
    test_mode = 1'b1;
    bist_mode = mode;
    step();
    cyc       = 0;
    bist_mode = 2'b00;
  endtask

  task automatic end_run();
    test_mode = 1'b0;
    step();
    step();
  endtask

  task automatic check_vector(input vec_t v);
    checkOutput("active", bist_active, v.active);
    checkOutput("enable", bist_enable, v.active);
    checkOutput("we", bist_icu_tag_we, v.we);
    checkOutput("addr", bist_icu_tag_addr, v.addr);
    checkOutput("wdata", {bist_icu_tag_vld, bist_icu_tag_in}, v.wdata);
    checkOutput("done", bist_done, v.done);
    checkOutput("err_l", itag_test_err_l, v.err_l);
    checkOutput("fail_addr", bist_fail_addr, 4'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, " active"}, bist_active, 1'b0);
    checkOutput({tag, " enable"}, bist_enable, 1'b0);
    checkOutput({tag, " we"}, bist_icu_tag_we, 1'b0);
    checkOutput({tag, " addr"}, bist_icu_tag_addr, 4'd0);
    checkOutput({tag, " wdata"}, {bist_icu_tag_vld, bist_icu_tag_in}, 19'h0);
    checkOutput({tag, " done"}, bist_done, 1'b0);
    checkOutput({tag, " err_l"}, itag_test_err_l, 1'b1);
    checkOutput({tag, " fail_addr"}, bist_fail_addr, 4'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b1;
    test_mode = 1'b0;
    bist_mode = 2'b00;
    fault_en  = 1'b0;

    // Solid background: P = 0, ~P = all ones.
    vecs.push_back(mk(2'b01,   0, 1, 1,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  15, 1, 1, 15, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  16, 1, 0,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  17, 1, 1,  0, 19'h7FFFF, 0, 1));
    vecs.push_back(mk(2'b01,  47, 1, 1, 15, 19'h7FFFF, 0, 1));
    vecs.push_back(mk(2'b01,  48, 1, 0,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  49, 1, 1,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  80, 1, 0, 15, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01,  81, 1, 1, 15, 19'h7FFFF, 0, 1));
    vecs.push_back(mk(2'b01,  82, 1, 0, 14, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 112, 1, 0, 15, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 113, 1, 1, 15, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 145, 1, 0, 15, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 174, 1, 0,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 175, 1, 0,  0, 19'h00000, 0, 1));
    vecs.push_back(mk(2'b01, 176, 0, 0,  0, 19'h00000, 1, 1));
    // Checkerboard: even index P = 0x2AAAA, odd index P = 0x55555.
    vecs.push_back(mk(2'b10,   0, 1, 1,  0, 19'h2AAAA, 0, 1));
    vecs.push_back(mk(2'b10,   1, 1, 1,  1, 19'h55555, 0, 1));
    vecs.push_back(mk(2'b10,  17, 1, 1,  0, 19'h55555, 0, 1));
    vecs.push_back(mk(2'b10,  19, 1, 1,  1, 19'h2AAAA, 0, 1));
    vecs.push_back(mk(2'b10,  49, 1, 1,  0, 19'h2AAAA, 0, 1));
    vecs.push_back(mk(2'b10,  81, 1, 1, 15, 19'h2AAAA, 0, 1));
    vecs.push_back(mk(2'b10, 113, 1, 1, 15, 19'h55555, 0, 1));
    vecs.push_back(mk(2'b10, 176, 0, 0,  0, 19'h00000, 1, 1));

    step();
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("reset");

    $display("[TB] mode 00 must not start");
    test_mode = 1'b1;
    bist_mode = 2'b00;
    repeat (4) step();
    checkOutput("mode00 active", bist_active, 1'b0);
    checkOutput("mode00 done", bist_done, 1'b0);
    test_mode = 1'b0;
    step();

    $display("[TB] table-driven march runs");
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode) begin
        end_run();
        applyStimulus(vecs[i].mode);
      end
      step_to(vecs[i].cyc);
      check_vector(vecs[i]);
    end
    end_run();

    $display("[TB] clear-only run");
    applyStimulus(2'b11);
    for (int i = 0; i < 16; i++) begin
      step_to(i);
      checkOutput("clr addr", bist_icu_tag_addr, i[3:0]);
      checkOutput("clr we", bist_icu_tag_we, 1'b1);
      checkOutput("clr wdata", {bist_icu_tag_vld, bist_icu_tag_in}, 19'h0);
    end
    step_to(16);
    checkOutput("clr done", bist_done, 1'b1);
    checkOutput("clr active", bist_active, 1'b0);
    checkOutput("clr err_l", itag_test_err_l, 1'b1);
    repeat (3) step();
    checkOutput("done hold", bist_done, 1'b1);
    checkOutput("done hold we", bist_icu_tag_we, 1'b0);
    test_mode = 1'b0;
    step();
    checkOutput("idle after done", bist_done, 1'b0);
    step();

    $display("[TB] checkerboard with stuck-at-1 at index 5");
    fault_en = 1'b1;
    applyStimulus(2'b10);
    step_to(27);
    checkOutput("fault err_l before", itag_test_err_l, 1'b1);
    step_to(28);
    checkOutput("fault err_l after", itag_test_err_l, 1'b0);
    checkOutput("fault fail_addr", bist_fail_addr, 4'd5);
    step_to(176);
    checkOutput("fault done", bist_done, 1'b1);
    checkOutput("fault err_l end", itag_test_err_l, 1'b0);
    checkOutput("fault fail_addr end", bist_fail_addr, 4'd5);
    test_mode = 1'b0;
    step();
    checkOutput("fault idle done", bist_done, 1'b0);
    checkOutput("fault idle err_l", itag_test_err_l, 1'b0);
    checkOutput("fault idle fail_addr", bist_fail_addr, 4'd5);
    step();

    $display("[TB] abort at cycle 40 then restart");
    applyStimulus(2'b10);
    step_to(40);
    test_mode = 1'b0;
    step();
    checkOutput("abort active", bist_active, 1'b0);
    checkOutput("abort we", bist_icu_tag_we, 1'b0);
    checkOutput("abort done", bist_done, 1'b0);
    checkOutput("abort err_l", itag_test_err_l, 1'b0);
    step();
    checkOutput("abort stays idle", bist_active, 1'b0);
    fault_en = 1'b0;
    applyStimulus(2'b01);
    checkOutput("restart err_l", itag_test_err_l, 1'b1);
    checkOutput("restart fail_addr", bist_fail_addr, 4'd0);
    checkOutput("restart active", bist_active, 1'b1);
    step_to(176);
    checkOutput("restart done", bist_done, 1'b1);
    checkOutput("restart err_l end", itag_test_err_l, 1'b1);
    end_run();

    $display("[TB] reset in M2 after a fault");
    fault_en = 1'b1;
    applyStimulus(2'b10);
    step_to(60);
    checkOutput("m2 err_l pre-reset", itag_test_err_l, 1'b0);
    checkOutput("m2 active pre-reset", bist_active, 1'b1);
    reset = 1'b1;
    step();
    check_reset_outputs("midrun reset");
    reset    = 1'b0;
    fault_en = 1'b0;
    step();
    checkOutput("post-reset idle", bist_active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
